ram_bank_ctrl: RTL and testbench

//  Parametrised single-port word RAM with a req/gnt handshake, registered read data and a

---
 rtl/ram_bank_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ram_bank_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl: single-port word RAM with req/gnt handshake, 1-cycle registered read and
// post-reset clear sweep. Define RAM_PARITY_EN to store and check one even-parity bit per byte.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | zeroing word k on cycle k after reset; no grants, busy_o=1
// READY | gnt_o=1 every cycle; reads and writes serviced
module ram_bank_ctrl #(
  parameter int DP         = 4096,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   data_i,
  output logic            rvalid_o,
  output logic [DW-1:0]   data_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = AW - OFF;
  localparam int MW  = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW  = (IW > 33) ? IW : 33;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLR_ON_RST ? CLEAR : READY;

  state_t          state;
  state_t          state_next;
  logic [MW-1:0]   clr_cnt;
  logic [MW-1:0]   clr_addr;
  logic [IW-1:0]   widx;
  logic [MW-1:0]   maddr;
  logic            in_range;
  logic            accept;
  logic            wr;
  logic            rd;
  logic            par_err;
  logic [DW-1:0]   rd_word;
  logic            addr_unused;

  logic [DW-1:0]   mem [DP];

  // Low address bits select a byte inside the word and carry no meaning here.
  assign addr_unused = ^addr_i;

  // Unsigned compare in a width that can never truncate DP, so index DP is out of range.
  assign widx     = addr_i[AW-1:OFF];
  assign maddr    = widx[MW-1:0];
  assign in_range = CW'(widx) < CW'(DP);

  assign accept   = req_i && gnt_o;
  assign wr       = accept && we_i && in_range;
  assign rd       = accept && !we_i;

  // Sweep counter runs down to terminal count 0; the address it drives runs up from 0.
  assign clr_addr = MW'(DP - 1) - clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      clr_cnt <= MW'(DP - 1);
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt - MW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt_o      = 1'b0;
    busy_o     = 1'b0;
    case (state)
      CLEAR: begin
        busy_o = 1'b1;
        if (clr_cnt == '0) begin
          state_next = READY;
        end
      end
      READY: begin
        // Without a sweep the FSM sits in READY during reset; keep the grant low there.
        gnt_o = rst_n;
      end
      default: begin
        state_next = RST_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) begin
          mem[maddr][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = mem[maddr];

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DP];
  logic [NB-1:0] par_wr;
  logic [NB-1:0] par_rd;

  always_comb begin
    par_wr = '0;
    par_rd = '0;
    for (int b = 0; b < NB; b++) begin
      par_wr[b] = ^data_i[8*b +: 8];
      par_rd[b] = ^rd_word[8*b +: 8];
    end
  end

  // All-zero parity matches all-zero data, so the sweep leaves every word consistent.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par[clr_addr] <= '0;
    end else if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) begin
          par[maddr][b] <= par_wr[b];
        end
      end
    end
  end

  assign par_err = in_range && (par_rd != par[maddr]);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      data_o   <= '0;
    end else begin
      rvalid_o <= rd;
      err_o    <= rd && (!in_range || par_err);
      if (rd) begin
        data_o <= in_range ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Self-checking bench for ram_bank_ctrl: array/counter reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_bank_ctrl;

  localparam int DP = 16;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = DW / 8;
`ifdef RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req_i  = 1'b0;
  logic          we_i   = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [NB-1:0] sel_i  = '0;
  logic [DW-1:0] data_i = '0;
  logic          gnt_o;
  logic          rvalid_o;
  logic          busy_o;
  logic          err_o;
  logic [DW-1:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;

  ram_bank_ctrl #(.DP(DP), .DW(DW), .AW(AW), .CLR_ON_RST(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .sel_i    (sel_i),
    .data_i   (data_i),
    .rvalid_o (rvalid_o),
    .data_o   (data_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  // Reference model: word array, per-byte corruption flags, edge count since reset release.
  logic [DW-1:0] m_mem [DP];
  logic [NB-1:0] m_bad [DP];
  int            edges    = 0;
  bit            e_rvalid = 1'b0;
  bit            e_err    = 1'b0;
  logic [DW-1:0] e_data   = '0;
  logic [29:0]   m_idx;
  bit            m_inr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges    = 0;
      e_rvalid = 1'b0;
      e_err    = 1'b0;
      e_data   = '0;
      for (int k = 0; k < DP; k++) begin
        m_mem[k] = '0;
        m_bad[k] = '0;
      end
    end else begin
      m_idx    = addr_i[31:2];
      m_inr    = m_idx < 30'(DP);
      e_rvalid = 1'b0;
      e_err    = 1'b0;
      if (edges >= DP && req_i) begin
        if (we_i) begin
          if (m_inr) begin
            for (int b = 0; b < NB; b++) begin
              if (sel_i[b]) begin
                m_mem[m_idx[3:0]][8*b +: 8] = data_i[8*b +: 8];
                m_bad[m_idx[3:0]][b] = 1'b0;
              end
            end
          end
        end else begin
          e_rvalid = 1'b1;
          e_data   = m_inr ? m_mem[m_idx[3:0]] : '0;
          e_err    = !m_inr || (PAR && (|m_bad[m_idx[3:0]]));
        end
      end
      if (edges < DP) edges++;
    end
  end

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt", DW'(gnt_o), DW'(rst_n && edges >= DP));
    if (rst_n) chk("busy", DW'(busy_o), DW'(edges < DP));
    chk("rvalid", DW'(rvalid_o), DW'(e_rvalid));
    chk("err", DW'(err_o), DW'(e_err));
    chk("data", data_o, e_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit w, logic [AW-1:0] a, logic [NB-1:0] s, logic [DW-1:0] d);
    req_i  = r;
    we_i   = w;
    addr_i = a;
    sel_i  = s;
    data_i = d;
    step();
    req_i  = 1'b0;
  endtask

  task automatic wait_clear(string nm);
    int cnt = 0;
    while (busy_o && cnt < 100) begin
      step();
      cnt++;
    end
    chk(nm, DW'(cnt), DW'(DP));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp4 [4];
    logic [AW-1:0] a4 [4];

    // Reset, then full sweep and all-zero contents
    repeat (3) step();
    rst_n = 1'b1;
    wait_clear("clear_len");
    chk("gnt_after_clear", DW'(gnt_o), DW'(1));
    for (int k = 0; k < DP; k++) begin
      drive(1'b1, 1'b0, AW'(k * 4), '0, '0);
      chk("clear_zero", data_o, '0);
      chk("clear_rvalid", DW'(rvalid_o), DW'(1));
    end

    // Backdoor bit flip in word 2
    drive(1'b0, 1'b0, '0, '0, '0);
    dut.mem[2][9] = ~dut.mem[2][9];
    m_mem[2][9]   = ~m_mem[2][9];
    m_bad[2][1]   = 1'b1;
    drive(1'b1, 1'b0, 32'h8, '0, '0);
    chk("par_data", data_o, 32'h0000_0200);
    chk("par_err", DW'(err_o), DW'(PAR));
    drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h0);

    // Byte-lane merge
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00AA);
    drive(1'b1, 1'b0, 32'h10, '0, '0);
    chk("merge_data", data_o, 32'hDEAD_BEAA);
    chk("merge_err", DW'(err_o), DW'(0));
    drive(1'b1, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h14, '0, '0);
    chk("sel0_noop", data_o, 32'h0);

    // Write then immediate read, then four back-to-back reads
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h20, '0, '0);
    chk("raw_data", data_o, 32'h1234_5678);
    drive(1'b1, 1'b1, 32'h30, 4'hC, 32'hA5A5_0000);
    a4[0] = 32'h10; exp4[0] = 32'hDEAD_BEAA;
    a4[1] = 32'h20; exp4[1] = 32'h1234_5678;
    a4[2] = 32'h00; exp4[2] = 32'h0;
    a4[3] = 32'h30; exp4[3] = 32'hA5A5_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, a4[i], '0, '0);
      chk("b2b_rvalid", DW'(rvalid_o), DW'(1));
      chk("b2b_data", data_o, exp4[i]);
    end

    // Out of range: index DP and a very high address
    drive(1'b1, 1'b0, 32'h40, '0, '0);
    chk("oob_rvalid", DW'(rvalid_o), DW'(1));
    chk("oob_err", DW'(err_o), DW'(1));
    chk("oob_data", data_o, 32'h0);
    drive(1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0, '0, '0);
    chk("oob_nowrap", data_o, 32'h0);
    drive(1'b1, 1'b0, 32'hFFFF_FFC0, '0, '0);
    chk("oob_high_err", DW'(err_o), DW'(1));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = {25'(0), 5'($urandom_range(0, 19)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) a = $urandom;
      drive($urandom_range(0, 3) != 0, 1'($urandom), a, 4'($urandom), $urandom);
    end

    // Reset mid-sweep restarts the full sweep
    drive(1'b1, 1'b1, 32'h3C, 4'hF, 32'h5555_AAAA);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("rst_busy_gnt", DW'(gnt_o), DW'(0));
    rst_n = 1'b1;
    wait_clear("resweep_len");
    drive(1'b1, 1'b0, 32'h3C, '0, '0);
    chk("resweep_zero", data_o, 32'h0);

    // Reset in the cycle after a read grant discards the read
    drive(1'b1, 1'b1, 32'h4, 4'hF, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, 32'h4, '0, '0);
    chk("pre_rst_data", data_o, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, 32'h4, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", DW'(rvalid_o), DW'(0));
    chk("rst_data", data_o, 32'h0);
    chk("rst_err", DW'(err_o), DW'(0));
    step();
    step();
    rst_n = 1'b1;
    wait_clear("final_clear_len");
    drive(1'b1, 1'b0, 32'h4, '0, '0);
    chk("final_zero", data_o, 32'h0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
